// File: rtl/maverickone_tagged_regfile_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : maverickone_tagged_regfile_pkg
//  Description : Shared sizes and types for the tagged register file
//                (register count, data width, producer tag width).
//  Revision    : 1.0 - initial release
// ============================================================================
package maverickone_tagged_regfile_pkg;

    localparam int NUM_REGS = 32;
    localparam int XLEN     = 32;
    localparam int TAG_W    = 4;

    // Producer tag (ROB index) of the newest in-flight writer of a register
    typedef logic [TAG_W-1:0] tag_t;

endpackage
`default_nettype wire

// File: rtl/maverickone_tagged_regfile_fwd.sv
`default_nettype none
// ============================================================================
//  Module      : maverickone_tagged_regfile_fwd
//  Description : One read port of the tagged register file. Returns stored
//                data, or forwards a same-cycle matching writeback, and
//                reports whether the operand is still pending (and on which
//                producer tag).
//  Revision    : 1.0 - initial release
// ============================================================================
module maverickone_tagged_regfile_fwd
    import maverickone_tagged_regfile_pkg::*;
#(
    parameter int NR  = NUM_REGS,
    parameter int DW  = XLEN,
    parameter int TW  = TAG_W,
    parameter int NWB = 2,
    localparam int AW = $clog2(NR)
) (
    input  logic [AW-1:0]           rs_addr_i,
    input  logic [NR-1:0]           lock_i,
    input  logic [NR-1:0][TW-1:0]   tag_i,
    input  logic [NR-1:0][DW-1:0]   data_i,
    input  logic [NWB-1:0]          wb_match_i,
    input  logic [NWB-1:0][AW-1:0]  wb_addr_i,
    input  logic [NWB-1:0][DW-1:0]  wb_data_i,
    output logic [DW-1:0]           rs_data_o,
    output logic                    rs_locked_o,
    output logic [TW-1:0]           rs_tag_o
);

    // Operand select: x0 reads as zero; a pending register is resolved by a
    // matching writeback this cycle, scanning from the highest port down so
    // that the lowest-index port has the final say.
    always_comb begin
        rs_data_o   = '0;
        rs_locked_o = 1'b0;
        rs_tag_o    = '0;
        if (rs_addr_i != '0) begin
            rs_data_o = data_i[rs_addr_i];
            if (lock_i[rs_addr_i]) begin
                rs_locked_o = 1'b1;
                rs_tag_o    = tag_i[rs_addr_i];
                for (int k = NWB - 1; k >= 0; k--) begin
                    if (wb_match_i[k] && (wb_addr_i[k] == rs_addr_i)) begin
                        rs_data_o   = wb_data_i[k];
                        rs_locked_o = 1'b0;
                        rs_tag_o    = '0;
                    end
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/maverickone_tagged_regfile.sv
`default_nettype none
// ============================================================================
//  Module      : maverickone_tagged_regfile
//  Description : Tagged multi-ported integer register file for out-of-order
//                issue. Each register holds a lock bit and the tag of its
//                newest producer; writebacks only land when their tag matches
//                the registered tag, so WAW-overwritten results are dropped.
//                Read ports forward same-cycle writebacks; flush clears locks.
//  Revision    : 1.0 - initial release
// ============================================================================
module maverickone_tagged_regfile
    import maverickone_tagged_regfile_pkg::*;
#(
    parameter int NR  = NUM_REGS,
    parameter int DW  = XLEN,
    parameter int TW  = TAG_W,
    parameter int NRP = 3,
    parameter int NWB = 2,
    localparam int AW = $clog2(NR)
) (
    input  logic                    clk_i,
    input  logic                    arst_ni,
    input  logic                    lock_en_i,
    input  logic [AW-1:0]           lock_addr_i,
    input  logic [TW-1:0]           lock_tag_i,
    input  logic [NWB-1:0]          wb_en_i,
    input  logic [NWB-1:0][AW-1:0]  wb_addr_i,
    input  logic [NWB-1:0][TW-1:0]  wb_tag_i,
    input  logic [NWB-1:0][DW-1:0]  wb_data_i,
    input  logic                    flush_i,
    input  logic [NRP-1:0][AW-1:0]  rs_addr_i,
    output logic [NRP-1:0][DW-1:0]  rs_data_o,
    output logic [NRP-1:0]          rs_locked_o,
    output logic [NRP-1:0][TW-1:0]  rs_tag_o,
    output logic [NR-1:0]           locks_o
);

    logic [NR-1:0]          lock_q,  lock_d;
    logic [NR-1:0][TW-1:0]  tag_q,   tag_d;
    logic [NR-1:0][DW-1:0]  data_q,  data_d;
    logic [NWB-1:0]         wb_match;
    logic                   lock_set;

    // A writeback is accepted only against the registered lock and tag
    always_comb begin
        wb_match = '0;
        for (int k = 0; k < NWB; k++) begin
            wb_match[k] = wb_en_i[k] && (wb_addr_i[k] != '0)
                          && lock_q[wb_addr_i[k]]
                          && (tag_q[wb_addr_i[k]] == wb_tag_i[k]);
        end
    end

    // Flush squashes any lock request made in the same cycle
    assign lock_set = lock_en_i && !flush_i && (lock_addr_i != '0);

    // Next-state: matching writebacks write data and release the lock, a new
    // lock then re-arms with the newest tag, and flush drops every lock.
    always_comb begin
        data_d = data_q;
        lock_d = lock_q;
        tag_d  = tag_q;
        for (int r = 1; r < NR; r++) begin
            for (int k = NWB - 1; k >= 0; k--) begin
                if (wb_match[k] && (wb_addr_i[k] == AW'(r))) begin
                    data_d[r] = wb_data_i[k];
                    lock_d[r] = 1'b0;
                end
            end
            if (lock_set && (lock_addr_i == AW'(r))) begin
                lock_d[r] = 1'b1;
                tag_d[r]  = lock_tag_i;
            end
        end
        if (flush_i) begin
            lock_d = '0;
        end
        data_d[0] = '0;
        lock_d[0] = 1'b0;
        tag_d[0]  = '0;
    end

    // State registers, cleared asynchronously
    always_ff @(posedge clk_i or negedge arst_ni) begin
        if (!arst_ni) begin
            lock_q <= '0;
            tag_q  <= '0;
            data_q <= '0;
        end else begin
            lock_q <= lock_d;
            tag_q  <= tag_d;
            data_q <= data_d;
        end
    end

    // Report every register as locked while in reset so issue stalls
    assign locks_o = arst_ni ? lock_q : '1;

    generate
        for (genvar p = 0; p < NRP; p++) begin : g_rd
            maverickone_tagged_regfile_fwd #(
                .NR  (NR),
                .DW  (DW),
                .TW  (TW),
                .NWB (NWB)
            ) u_fwd (
                .rs_addr_i   (rs_addr_i[p]),
                .lock_i      (lock_q),
                .tag_i       (tag_q),
                .data_i      (data_q),
                .wb_match_i  (wb_match),
                .wb_addr_i   (wb_addr_i),
                .wb_data_i   (wb_data_i),
                .rs_data_o   (rs_data_o[p]),
                .rs_locked_o (rs_locked_o[p]),
                .rs_tag_o    (rs_tag_o[p])
            );
        end
    endgenerate

    // Two matching writebacks to one register in a cycle is illegal upstream
    generate
        for (genvar i = 0; i < NWB; i++) begin : g_sva_i
            for (genvar j = i + 1; j < NWB; j++) begin : g_sva_j
                a_dup_wb: assert property (@(posedge clk_i) disable iff (!arst_ni)
                    !(wb_match[i] && wb_match[j] && (wb_addr_i[i] == wb_addr_i[j])));
            end
        end
    endgenerate

endmodule
`default_nettype wire

// File: tb/tb_maverickone_tagged_regfile.sv
`default_nettype none
// ============================================================================
//  Module      : tb_maverickone_tagged_regfile
//  Description : Self-checking bench for the tagged register file: directed
//                scenarios plus randomized traffic against a behavioural model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_maverickone_tagged_regfile;
    import maverickone_tagged_regfile_pkg::*;

    localparam int NR  = NUM_REGS;
    localparam int DW  = XLEN;
    localparam int TW  = TAG_W;
    localparam int NRP = 3;
    localparam int NWB = 2;
    localparam int AW  = $clog2(NR);

    logic                   clk_i = 1'b0;
    logic                   arst_ni;
    logic                   lock_en_i;
    logic [AW-1:0]          lock_addr_i;
    logic [TW-1:0]          lock_tag_i;
    logic [NWB-1:0]         wb_en_i;
    logic [NWB-1:0][AW-1:0] wb_addr_i;
    logic [NWB-1:0][TW-1:0] wb_tag_i;
    logic [NWB-1:0][DW-1:0] wb_data_i;
    logic                   flush_i;
    logic [NRP-1:0][AW-1:0] rs_addr_i;
    logic [NRP-1:0][DW-1:0] rs_data_o;
    logic [NRP-1:0]         rs_locked_o;
    logic [NRP-1:0][TW-1:0] rs_tag_o;
    logic [NR-1:0]          locks_o;

    int total = 0;
    int bad   = 0;

    // Behavioural model of the architectural state
    logic [DW-1:0] m_data [NR];
    bit            m_lock [NR];
    logic [TW-1:0] m_tag  [NR];

    maverickone_tagged_regfile #(
        .NR(NR), .DW(DW), .TW(TW), .NRP(NRP), .NWB(NWB)
    ) dut (
        .clk_i       (clk_i),
        .arst_ni     (arst_ni),
        .lock_en_i   (lock_en_i),
        .lock_addr_i (lock_addr_i),
        .lock_tag_i  (lock_tag_i),
        .wb_en_i     (wb_en_i),
        .wb_addr_i   (wb_addr_i),
        .wb_tag_i    (wb_tag_i),
        .wb_data_i   (wb_data_i),
        .flush_i     (flush_i),
        .rs_addr_i   (rs_addr_i),
        .rs_data_o   (rs_data_o),
        .rs_locked_o (rs_locked_o),
        .rs_tag_o    (rs_tag_o),
        .locks_o     (locks_o)
    );

    always #5 clk_i = ~clk_i;

    // Expected read result given the model state and the current writebacks
    function automatic void model_read(input int a, output logic [DW-1:0] d,
                                       output logic l, output logic [TW-1:0] t);
        d = '0; l = 1'b0; t = '0;
        if (a == 0) return;
        d = m_data[a];
        if (m_lock[a]) begin
            l = 1'b1;
            t = m_tag[a];
            for (int k = 0; k < NWB; k++) begin
                if (wb_en_i[k] && int'(wb_addr_i[k]) == a && wb_tag_i[k] == m_tag[a]) begin
                    d = wb_data_i[k];
                    l = 1'b0;
                    t = '0;
                    break;
                end
            end
        end
    endfunction

    function automatic logic [NR-1:0] model_locks();
        logic [NR-1:0] v;
        for (int i = 0; i < NR; i++) v[i] = m_lock[i];
        return v;
    endfunction

    // Advance the model by one clock using the inputs applied this cycle
    task automatic model_update();
        bit hit [NWB];
        int a;
        for (int k = 0; k < NWB; k++) begin
            a = int'(wb_addr_i[k]);
            hit[k] = wb_en_i[k] && a != 0 && m_lock[a] && m_tag[a] == wb_tag_i[k];
        end
        for (int k = NWB - 1; k >= 0; k--) begin
            if (hit[k]) begin
                m_data[int'(wb_addr_i[k])] = wb_data_i[k];
                m_lock[int'(wb_addr_i[k])] = 1'b0;
            end
        end
        if (flush_i) begin
            for (int i = 0; i < NR; i++) m_lock[i] = 1'b0;
        end else if (lock_en_i && lock_addr_i != '0) begin
            m_lock[int'(lock_addr_i)] = 1'b1;
            m_tag[int'(lock_addr_i)]  = lock_tag_i;
        end
    endtask

    task automatic step();
        @(posedge clk_i);
        model_update();
        #1;
        lock_en_i = 1'b0;
        wb_en_i   = '0;
        flush_i   = 1'b0;
    endtask

    task automatic set_lock(input int a, input int t);
        lock_en_i   = 1'b1;
        lock_addr_i = AW'(a);
        lock_tag_i  = TW'(t);
    endtask

    task automatic set_wb(input int k, input int a, input int t, input logic [DW-1:0] d);
        wb_en_i[k]   = 1'b1;
        wb_addr_i[k] = AW'(a);
        wb_tag_i[k]  = TW'(t);
        wb_data_i[k] = d;
    endtask

    task automatic test_reset();
        arst_ni = 1'b0; lock_en_i = 1'b0; lock_addr_i = '0; lock_tag_i = '0;
        wb_en_i = '0; wb_addr_i = '0; wb_tag_i = '0; wb_data_i = '0; flush_i = 1'b0;
        for (int p = 0; p < NRP; p++) rs_addr_i[p] = AW'(5);
        for (int i = 0; i < NR; i++) begin m_data[i] = '0; m_lock[i] = 1'b0; m_tag[i] = '0; end
        #3;
        total++;
        if (locks_o !== '1) begin bad++; $display("FAIL reset_locks got=%h exp=%h", locks_o, {NR{1'b1}}); end
        for (int p = 0; p < NRP; p++) begin
            total++;
            if (rs_data_o[p] !== '0 || rs_locked_o[p] !== 1'b0) begin
                bad++; $display("FAIL reset_read p%0d got=%h/%b exp=0/0", p, rs_data_o[p], rs_locked_o[p]);
            end
        end
        #5 arst_ni = 1'b1;
        #1;
        total++;
        if (locks_o !== '0) begin bad++; $display("FAIL post_reset_locks got=%h exp=0", locks_o); end
        @(posedge clk_i); #1;
    endtask

    task automatic test_forward();
        for (int p = 0; p < NRP; p++) rs_addr_i[p] = AW'(5);
        set_lock(5, 3); #2;
        step();
        total++;
        if (locks_o[5] !== 1'b1) begin bad++; $display("FAIL fwd_lock got=%b exp=1", locks_o[5]); end
        set_wb(0, 5, 3, 32'hAA); #2;
        total++;
        if (rs_data_o[0] !== 32'hAA || rs_locked_o[0] !== 1'b0) begin
            bad++; $display("FAIL fwd_bypass got=%h/%b exp=aa/0", rs_data_o[0], rs_locked_o[0]);
        end
        step();
        total++;
        if (locks_o[5] !== 1'b0) begin bad++; $display("FAIL fwd_unlock got=%b exp=0", locks_o[5]); end
        #2;
        total++;
        if (rs_data_o[1] !== 32'hAA || rs_locked_o[1] !== 1'b0) begin
            bad++; $display("FAIL fwd_stored got=%h/%b exp=aa/0", rs_data_o[1], rs_locked_o[1]);
        end
    endtask

    task automatic test_waw();
        for (int p = 0; p < NRP; p++) rs_addr_i[p] = AW'(7);
        set_lock(7, 1); step();
        set_lock(7, 4); step();
        set_wb(0, 7, 1, 32'h11); #2;
        total++;
        if (rs_data_o[0] !== 32'h0 || rs_locked_o[0] !== 1'b1 || rs_tag_o[0] !== 4'd4) begin
            bad++; $display("FAIL waw_stale_read got=%h/%b/%h exp=0/1/4", rs_data_o[0], rs_locked_o[0], rs_tag_o[0]);
        end
        step();
        total++;
        if (locks_o[7] !== 1'b1) begin bad++; $display("FAIL waw_still_locked got=%b exp=1", locks_o[7]); end
        set_wb(1, 7, 4, 32'h44); #2;
        total++;
        if (rs_data_o[2] !== 32'h44 || rs_locked_o[2] !== 1'b0) begin
            bad++; $display("FAIL waw_fwd got=%h/%b exp=44/0", rs_data_o[2], rs_locked_o[2]);
        end
        step(); #2;
        total++;
        if (locks_o[7] !== 1'b0 || rs_data_o[0] !== 32'h44) begin
            bad++; $display("FAIL waw_final got=%b/%h exp=0/44", locks_o[7], rs_data_o[0]);
        end
    endtask

    task automatic test_lock_and_wb();
        for (int p = 0; p < NRP; p++) rs_addr_i[p] = AW'(9);
        set_lock(9, 2); step();
        set_lock(9, 6); set_wb(1, 9, 2, 32'h99); step(); #2;
        total++;
        if (locks_o[9] !== 1'b1 || rs_data_o[0] !== 32'h99 || rs_locked_o[0] !== 1'b1 || rs_tag_o[0] !== 4'd6) begin
            bad++; $display("FAIL lock_wb got=%b/%h/%b/%h exp=1/99/1/6",
                            locks_o[9], rs_data_o[0], rs_locked_o[0], rs_tag_o[0]);
        end
    endtask

    task automatic test_flush();
        for (int a = 1; a <= 4; a++) begin set_lock(a, a); step(); end
        total++;
        if (locks_o[4:1] !== 4'hF) begin bad++; $display("FAIL flush_pre got=%h exp=f", locks_o[4:1]); end
        rs_addr_i[0] = AW'(2); rs_addr_i[1] = AW'(10); rs_addr_i[2] = AW'(3);
        flush_i = 1'b1; set_lock(10, 7); set_wb(0, 2, 2, 32'h22);
        step(); #2;
        total++;
        if (locks_o !== '0) begin bad++; $display("FAIL flush_locks got=%h exp=0", locks_o); end
        total++;
        if (rs_data_o[0] !== 32'h22 || rs_locked_o[0] !== 1'b0 || rs_locked_o[1] !== 1'b0) begin
            bad++; $display("FAIL flush_wb got=%h/%b/%b exp=22/0/0", rs_data_o[0], rs_locked_o[0], rs_locked_o[1]);
        end
    endtask

    task automatic test_x0();
        for (int p = 0; p < NRP; p++) rs_addr_i[p] = '0;
        set_lock(0, 5); set_wb(0, 0, 5, 32'hFF); #2;
        total++;
        if (rs_data_o[0] !== '0 || rs_locked_o[0] !== 1'b0 || rs_tag_o[0] !== '0) begin
            bad++; $display("FAIL x0_read got=%h/%b/%h exp=0/0/0", rs_data_o[0], rs_locked_o[0], rs_tag_o[0]);
        end
        step(); #2;
        total++;
        if (locks_o[0] !== 1'b0 || rs_data_o[1] !== '0) begin
            bad++; $display("FAIL x0_after got=%b/%h exp=0/0", locks_o[0], rs_data_o[1]);
        end
    endtask

    task automatic test_random();
        logic [DW-1:0] ed;
        logic          el;
        logic [TW-1:0] et;
        int            locked_q[$];
        int            a, a0;
        for (int c = 0; c < 300; c++) begin
            locked_q = {};
            for (int i = 1; i < NR; i++) if (m_lock[i]) locked_q.push_back(i);
            lock_en_i   = ($urandom_range(0, 1) == 1);
            lock_addr_i = AW'($urandom_range(0, 15));
            lock_tag_i  = TW'($urandom);
            flush_i     = ($urandom_range(0, 15) == 0);
            a0 = -1;
            for (int k = 0; k < NWB; k++) begin
                if (locked_q.size() > 0 && $urandom_range(0, 1) == 1) begin
                    a = locked_q[$urandom_range(0, locked_q.size() - 1)];
                    wb_tag_i[k] = ($urandom_range(0, 3) == 0) ? TW'($urandom) : m_tag[a];
                end else begin
                    a = $urandom_range(0, 15);
                    wb_tag_i[k] = TW'($urandom);
                end
                wb_addr_i[k] = AW'(a);
                wb_data_i[k] = $urandom;
                wb_en_i[k]   = ($urandom_range(0, 3) != 0) && (a != a0);
                a0 = a;
            end
            for (int p = 0; p < NRP; p++) begin
                if (locked_q.size() > 0 && $urandom_range(0, 1) == 1)
                    rs_addr_i[p] = AW'(locked_q[$urandom_range(0, locked_q.size() - 1)]);
                else
                    rs_addr_i[p] = AW'($urandom_range(0, 15));
            end
            #2;
            for (int p = 0; p < NRP; p++) begin
                model_read(int'(rs_addr_i[p]), ed, el, et);
                total++;
                if (rs_data_o[p] !== ed || rs_locked_o[p] !== el || (el && rs_tag_o[p] !== et)) begin
                    bad++; $display("FAIL rand_read c%0d p%0d a=%0d got=%h/%b/%h exp=%h/%b/%h", c, p,
                                    rs_addr_i[p], rs_data_o[p], rs_locked_o[p], rs_tag_o[p], ed, el, et);
                end
            end
            step();
            total++;
            if (locks_o !== model_locks()) begin
                bad++; $display("FAIL rand_locks c%0d got=%h exp=%h", c, locks_o, model_locks());
            end
        end
    endtask

    initial begin
        test_reset();
        test_forward();
        test_waw();
        test_lock_and_wb();
        test_flush();
        test_x0();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
